// File: rtl/register_free_list_multi_port_pkg.sv
// Shared configuration for the physical register free list.
// Optional feature macro: REGISTER_FREE_LIST_BYPASS_EN (same-cycle free-to-alloc forwarding).
package register_free_list_multi_port_pkg;

  localparam int unsigned NUM_PHYS_REGS = 64;
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned PHYS_ADDR_W   = $clog2(NUM_PHYS_REGS);

  typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } free_list_state_t;

endpackage

// File: rtl/register_free_list_multi_port_compactor.sv
// Prefix-rank of the free_valid vector: each valid port gets its compacted slot offset,
// and the total number of valid ports is reported as the push count.
module register_free_list_multi_port_compactor #(
  parameter int unsigned FREE_PORTS = 2,
  localparam int unsigned RANK_W    = $clog2(FREE_PORTS + 1)
) (
  input  logic [FREE_PORTS-1:0]        valid_i,
  output logic [FREE_PORTS*RANK_W-1:0] rank_o,
  output logic [RANK_W-1:0]            push_cnt_o
);

  // Running count of valid ports below each port
  always_comb begin
    logic [RANK_W-1:0] acc;
    acc    = '0;
    rank_o = '0;
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      rank_o[p*RANK_W +: RANK_W] = acc;
      acc = acc + RANK_W'(valid_i[p]);
    end
    push_cnt_o = acc;
  end

endmodule

// File: rtl/register_free_list_multi_port.sv
// Circular free list of physical register IDs with multi-port allocate/free and rollback.
// Self-initialises after rst with every non-architectural ID.
// Optional feature macro: REGISTER_FREE_LIST_BYPASS_EN forwards same-cycle frees to allocators.
module register_free_list_multi_port
  import register_free_list_multi_port_pkg::*;
#(
  parameter int unsigned ALLOC_PORTS  = 2,
  parameter int unsigned FREE_PORTS   = 2,
  parameter int unsigned MAX_ROLLBACK = 8,
  localparam int unsigned NUM_FREE    = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int unsigned DEPTH       = 2 ** $clog2(NUM_FREE),
  localparam int unsigned IDX_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = IDX_W + 1,
  localparam int unsigned RB_W        = $clog2(MAX_ROLLBACK + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               ready,
  input  logic [ALLOC_PORTS-1:0]             alloc_req,
  output logic [ALLOC_PORTS-1:0]             alloc_valid,
  output logic [ALLOC_PORTS*PHYS_ADDR_W-1:0] alloc_id,
  input  logic [FREE_PORTS-1:0]              free_valid,
  input  logic [FREE_PORTS*PHYS_ADDR_W-1:0]  free_id,
  input  logic                               rollback,
  input  logic [RB_W-1:0]                    rollback_count,
  output logic [CNT_W-1:0]                   free_count,
  output logic                               empty
);

  localparam int unsigned RANK_W = $clog2(FREE_PORTS + 1);

  free_list_state_t  state_q, state_d;
  logic [IDX_W-1:0]  init_ctr_q, init_ctr_d;
  logic [IDX_W-1:0]  read_idx_q, read_idx_d;
  logic [IDX_W-1:0]  write_idx_q, write_idx_d;
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  phys_addr_t        ram_q [DEPTH];

  logic [FREE_PORTS-1:0] wr_en;
  logic [IDX_W-1:0]      wr_idx  [FREE_PORTS];
  phys_addr_t            wr_data [FREE_PORTS];

  logic [FREE_PORTS*RANK_W-1:0] rank;
  logic [RANK_W-1:0]            pushes;

  register_free_list_multi_port_compactor #(
    .FREE_PORTS (FREE_PORTS)
  ) u_compactor (
    .valid_i    (free_valid),
    .rank_o     (rank),
    .push_cnt_o (pushes)
  );

  assign ready      = (state_q == StRun);
  assign free_count = free_count_q;
  assign empty      = (free_count_q == '0);

  // Init sequencing, allocation offers, free compaction and pointer/count updates
  always_comb begin
    int unsigned fc, psh, rb, avail, pops, byp, rk;
    state_d      = state_q;
    init_ctr_d   = init_ctr_q;
    read_idx_d   = read_idx_q;
    write_idx_d  = write_idx_q;
    free_count_d = free_count_q;
    wr_en        = '0;
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      wr_idx[p]  = '0;
      wr_data[p] = '0;
    end
    alloc_valid = '0;
    alloc_id    = '0;
    fc    = 32'(free_count_q);
    psh   = 32'(pushes);
    rb    = rollback ? 32'(rollback_count) : 0;
    avail = fc;
    pops  = 0;
    byp   = 0;
    rk    = 0;

    unique case (state_q)
      StInit: begin
        wr_en[0]   = 1'b1;
        wr_idx[0]  = init_ctr_q;
        wr_data[0] = PHYS_ADDR_W'(NUM_ARCH_REGS + 32'(init_ctr_q));
        init_ctr_d = init_ctr_q + 1'b1;
        if (32'(init_ctr_q) == NUM_FREE - 1) begin
          state_d      = StRun;
          read_idx_d   = '0;
          write_idx_d  = IDX_W'(NUM_FREE % DEPTH);
          free_count_d = CNT_W'(NUM_FREE);
        end
      end

      StRun: begin
`ifdef REGISTER_FREE_LIST_BYPASS_EN
        avail = fc + psh;
`endif
        for (int i = 0; i < int'(ALLOC_PORTS); i++) begin
          alloc_id[i*PHYS_ADDR_W +: PHYS_ADDR_W] = ram_q[read_idx_q + IDX_W'(i)];
          alloc_valid[i] = !rollback && (avail > unsigned'(i));
`ifdef REGISTER_FREE_LIST_BYPASS_EN
          // Ports beyond the stored entries take frees in compacted order
          if (unsigned'(i) >= fc) begin
            for (int p = 0; p < int'(FREE_PORTS); p++) begin
              if (free_valid[p] && (32'(rank[p*RANK_W +: RANK_W]) == unsigned'(i) - fc)) begin
                alloc_id[i*PHYS_ADDR_W +: PHYS_ADDR_W] = free_id[p*PHYS_ADDR_W +: PHYS_ADDR_W];
              end
            end
          end
`endif
          if (alloc_req[i] && alloc_valid[i]) pops = pops + 1;
        end
`ifdef REGISTER_FREE_LIST_BYPASS_EN
        byp = (pops > fc) ? pops - fc : 0;
`endif
        // Frees consumed by the bypass never touch the RAM
        for (int p = 0; p < int'(FREE_PORTS); p++) begin
          rk = 32'(rank[p*RANK_W +: RANK_W]);
          if (free_valid[p] && rk >= byp) begin
            wr_en[p]   = 1'b1;
            wr_idx[p]  = write_idx_q + IDX_W'(rk - byp);
            wr_data[p] = free_id[p*PHYS_ADDR_W +: PHYS_ADDR_W];
          end
        end
        write_idx_d  = write_idx_q + IDX_W'(psh - byp);
        read_idx_d   = read_idx_q + IDX_W'(pops - byp) - IDX_W'(rb);
        free_count_d = CNT_W'(fc + psh + rb - pops);
      end

      default: state_d = StInit;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      init_ctr_q   <= '0;
      read_idx_q   <= '0;
      write_idx_q  <= '0;
      free_count_q <= '0;
    end else begin
      state_q      <= state_d;
      init_ctr_q   <= init_ctr_d;
      read_idx_q   <= read_idx_d;
      write_idx_q  <= write_idx_d;
      free_count_q <= free_count_d;
    end
  end

  // LUT RAM storage, one write port per free port, no reset
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      if (wr_en[p]) ram_q[wr_idx[p]] <= wr_data[p];
    end
  end

  logic overfill;
  assign overfill = ready && (pushes != '0) &&
                    ((32'(free_count_q) + 32'(pushes) + (rollback ? 32'(rollback_count) : 0))
                     > DEPTH);

  // Caller contract checks
  a_req_prefix: assert property (@(posedge clk) disable iff (rst)
    ((alloc_req & (alloc_req + ALLOC_PORTS'(1))) == '0));
  a_no_overfill: assert property (@(posedge clk) disable iff (rst) !overfill);
  a_rb_count: assert property (@(posedge clk) disable iff (rst)
    (32'(rollback_count) <= MAX_ROLLBACK));

endmodule

// File: tb/tb_register_free_list_multi_port.sv
// Self-checking bench for register_free_list_multi_port (64/32 config, 2 alloc / 2 free ports).
module tb_register_free_list_multi_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_valid;
  logic [11:0] alloc_id;
  logic [1:0]  free_valid;
  logic [11:0] free_id;
  logic        rollback;
  logic [3:0]  rollback_count;
  logic [5:0]  free_count;
  logic        empty;

  int vectors    = 0;
  int miscompares = 0;

  register_free_list_multi_port dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .alloc_req      (alloc_req),
    .alloc_valid    (alloc_valid),
    .alloc_id       (alloc_id),
    .free_valid     (free_valid),
    .free_id        (free_id),
    .rollback       (rollback),
    .rollback_count (rollback_count),
    .free_count     (free_count),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] aid(input int k);
    return alloc_id[k*6 +: 6];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req      = 2'b00;
    free_valid     = 2'b00;
    free_id        = '0;
    rollback       = 1'b0;
    rollback_count = '0;
  endtask

  task automatic bring_up();
    int n;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bring_up_ready: ready=%b after %0d cycles, want 1", ready, n);
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    vectors += 4;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", ready); end
    if (alloc_valid !== 2'b00) begin
      miscompares++; $display("FAIL rst_alloc_valid: got %b want 00", alloc_valid);
    end
    if (free_count !== 6'd0) begin
      miscompares++; $display("FAIL rst_free_count: got %0d want 0", free_count);
    end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    vectors += 6;
    if (n != 32) begin miscompares++; $display("FAIL init_latency: got %0d want 32", n); end
    if (free_count !== 6'd32) begin
      miscompares++; $display("FAIL init_free_count: got %0d want 32", free_count);
    end
    if (empty !== 1'b0) begin miscompares++; $display("FAIL init_empty: got %b want 0", empty); end
    if (alloc_valid !== 2'b11) begin
      miscompares++; $display("FAIL init_alloc_valid: got %b want 11", alloc_valid);
    end
    if (aid(0) !== 6'd32) begin miscompares++; $display("FAIL init_id0: got %0d want 32", aid(0)); end
    if (aid(1) !== 6'd33) begin miscompares++; $display("FAIL init_id1: got %0d want 33", aid(1)); end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 16; c++) begin
      alloc_req = 2'b11;
      #1;
      vectors += 3;
      if (alloc_valid !== 2'b11) begin
        miscompares++; $display("FAIL drain_valid[%0d]: got %b want 11", c, alloc_valid);
      end
      if (aid(0) !== 6'(32 + 2*c)) begin
        miscompares++; $display("FAIL drain_id0[%0d]: got %0d want %0d", c, aid(0), 32 + 2*c);
      end
      if (aid(1) !== 6'(33 + 2*c)) begin
        miscompares++; $display("FAIL drain_id1[%0d]: got %0d want %0d", c, aid(1), 33 + 2*c);
      end
      tick();
    end
    alloc_req = 2'b11;
    #1;
    vectors += 3;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
    if (alloc_valid !== 2'b00) begin
      miscompares++; $display("FAIL drain_valid_empty: got %b want 00", alloc_valid);
    end
    if (free_count !== 6'd0) begin
      miscompares++; $display("FAIL drain_count: got %0d want 0", free_count);
    end
    tick();
    alloc_req = 2'b00;
    vectors++;
    if (free_count !== 6'd0) begin
      miscompares++; $display("FAIL drop_req_count: got %0d want 0", free_count);
    end
  endtask

  task automatic test_free_empty();
    free_valid = 2'b10;
    free_id    = {6'd5, 6'd0};
    tick();
    free_valid = 2'b01;
    free_id    = {6'd0, 6'd7};
    #1;
    vectors += 3;
    if (free_count !== 6'd1) begin miscompares++; $display("FAIL free1_count: got %0d want 1", free_count); end
    if (alloc_valid !== 2'b01) begin
      miscompares++; $display("FAIL free1_valid: got %b want 01", alloc_valid);
    end
    if (aid(0) !== 6'd5) begin miscompares++; $display("FAIL free1_id0: got %0d want 5", aid(0)); end
    tick();
    free_valid = 2'b00;
    vectors += 4;
    if (free_count !== 6'd2) begin miscompares++; $display("FAIL free2_count: got %0d want 2", free_count); end
    if (alloc_valid !== 2'b11) begin
      miscompares++; $display("FAIL free2_valid: got %b want 11", alloc_valid);
    end
    if (aid(0) !== 6'd5) begin miscompares++; $display("FAIL free2_id0: got %0d want 5", aid(0)); end
    if (aid(1) !== 6'd7) begin miscompares++; $display("FAIL free2_id1: got %0d want 7", aid(1)); end
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    vectors++;
    if (free_count !== 6'd0) begin miscompares++; $display("FAIL free_realloc: got %0d want 0", free_count); end
  endtask

  task automatic test_rollback();
    bring_up();
    alloc_req = 2'b11;
    tick();
    tick();
    rollback       = 1'b1;
    rollback_count = 4'd3;
    #1;
    vectors++;
    if (alloc_valid !== 2'b00) begin
      miscompares++; $display("FAIL rb_block: got %b want 00", alloc_valid);
    end
    tick();
    idle();
    #1;
    vectors += 2;
    if (aid(0) !== 6'd33) begin miscompares++; $display("FAIL rb_id0: got %0d want 33", aid(0)); end
    if (free_count !== 6'd31) begin miscompares++; $display("FAIL rb_count: got %0d want 31", free_count); end
  endtask

  task automatic test_rollback_free_wrap();
    int exp;
    bring_up();
    alloc_req = 2'b11;
    repeat (16) tick();
    alloc_req = 2'b00;
    for (int c = 0; c < 15; c++) begin
      free_valid = 2'b11;
      free_id    = {6'(33 + 2*c), 6'(32 + 2*c)};
      tick();
    end
    free_valid = 2'b01;
    free_id    = {6'd0, 6'd62};
    tick();
    free_valid = 2'b00;
    vectors++;
    if (free_count !== 6'd31) begin miscompares++; $display("FAIL wrap_fill: got %0d want 31", free_count); end
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b00;
    vectors++;
    if (free_count !== 6'd28) begin miscompares++; $display("FAIL wrap_pre: got %0d want 28", free_count); end
    rollback       = 1'b1;
    rollback_count = 4'd2;
    free_valid     = 2'b11;
    free_id        = {6'd32, 6'd63};
    tick();
    idle();
    vectors += 3;
    if (free_count !== 6'd32) begin miscompares++; $display("FAIL wrap_count: got %0d want 32", free_count); end
    if (aid(0) !== 6'd33) begin miscompares++; $display("FAIL wrap_id0: got %0d want 33", aid(0)); end
    if (aid(1) !== 6'd34) begin miscompares++; $display("FAIL wrap_id1: got %0d want 34", aid(1)); end
    for (int k = 0; k < 32; k++) begin
      exp = (k < 30) ? 33 + k : (k == 30 ? 63 : 32);
      alloc_req = 2'b01;
      #1;
      vectors++;
      if (aid(0) !== 6'(exp)) begin
        miscompares++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", k, aid(0), exp);
      end
      tick();
    end
    alloc_req = 2'b00;
  endtask

  task automatic test_reset_mid_init();
    int n;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL mid_init_ready: got %b want 0", ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    vectors += 3;
    if (n != 32) begin miscompares++; $display("FAIL mid_init_latency: got %0d want 32", n); end
    if (aid(0) !== 6'd32) begin miscompares++; $display("FAIL mid_init_id0: got %0d want 32", aid(0)); end
    if (free_count !== 6'd32) begin
      miscompares++; $display("FAIL mid_init_count: got %0d want 32", free_count);
    end
  endtask

`ifdef REGISTER_FREE_LIST_BYPASS_EN
  task automatic test_bypass();
    bring_up();
    alloc_req = 2'b11;
    repeat (16) tick();
    alloc_req  = 2'b01;
    free_valid = 2'b01;
    free_id    = {6'd0, 6'd9};
    #1;
    vectors += 2;
    if (alloc_valid !== 2'b01) begin
      miscompares++; $display("FAIL bypass_valid: got %b want 01", alloc_valid);
    end
    if (aid(0) !== 6'd9) begin miscompares++; $display("FAIL bypass_id: got %0d want 9", aid(0)); end
    tick();
    idle();
    vectors++;
    if (free_count !== 6'd0) begin miscompares++; $display("FAIL bypass_count: got %0d want 0", free_count); end
  endtask
`endif

  // Reference: free list as an ordered queue of IDs, outstanding allocations in age order
  task automatic test_random();
    int fl[$];
    int outst[$];
    int avail[$];
    int frees[$];
    int nreq, nfree, rbc, nv, pops, maxrb, id;
    logic rb_en;
    bring_up();
    for (int i = 32; i < 64; i++) fl.push_back(i);
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      nreq = $urandom_range(0, 2);
      alloc_req = (nreq == 0) ? 2'b00 : (nreq == 1 ? 2'b01 : 2'b11);
      nfree = $urandom_range(0, (outst.size() < 2) ? outst.size() : 2);
      frees.delete();
      for (int j = 0; j < nfree; j++) frees.push_back(outst.pop_front());
      if (nfree == 2) begin
        free_valid = 2'b11;
        free_id    = {6'(frees[1]), 6'(frees[0])};
      end else if (nfree == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          free_valid = 2'b10;
          free_id    = {6'(frees[0]), 6'd0};
        end else begin
          free_valid = 2'b01;
          free_id    = {6'd0, 6'(frees[0])};
        end
      end
      rb_en = 1'b0;
      rbc   = 0;
`ifndef REGISTER_FREE_LIST_BYPASS_EN
      maxrb = (outst.size() < 8) ? outst.size() : 8;
      if ($urandom_range(0, 5) == 0) begin
        rb_en = 1'b1;
        rbc   = $urandom_range(0, maxrb);
      end
`endif
      rollback       = rb_en;
      rollback_count = 4'(rbc);
      avail = fl;
`ifdef REGISTER_FREE_LIST_BYPASS_EN
      foreach (frees[j]) avail.push_back(frees[j]);
`endif
      nv = rb_en ? 0 : ((avail.size() < 2) ? avail.size() : 2);
      #1;
      vectors += 3;
      if (alloc_valid !== 2'((1 << nv) - 1)) begin
        miscompares++;
        $display("FAIL rand_valid[%0d]: got %b want %0d ports", cyc, alloc_valid, nv);
      end
      if (free_count !== 6'(fl.size())) begin
        miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, free_count, fl.size());
      end
      if (empty !== (fl.size() == 0)) begin
        miscompares++; $display("FAIL rand_empty[%0d]: got %b want %0d", cyc, empty, fl.size() == 0);
      end
      for (int i = 0; i < nv; i++) begin
        vectors++;
        if (aid(i) !== 6'(avail[i])) begin
          miscompares++;
          $display("FAIL rand_id[%0d][%0d]: got %0d want %0d", cyc, i, aid(i), avail[i]);
        end
      end
      pops = (nreq < nv) ? nreq : nv;
`ifdef REGISTER_FREE_LIST_BYPASS_EN
      for (int i = 0; i < pops; i++) outst.push_back(avail.pop_front());
      fl = avail;
`else
      for (int i = 0; i < pops; i++) outst.push_back(fl.pop_front());
      foreach (frees[j]) fl.push_back(frees[j]);
`endif
      if (rb_en) begin
        for (int j = 0; j < rbc; j++) begin
          id = outst.pop_back();
          fl.push_front(id);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_drain();
    test_free_empty();
    test_rollback();
    test_rollback_free_wrap();
    test_reset_mid_init();
`ifdef REGISTER_FREE_LIST_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
